// File: rtl/bcd_seg_timebase_if.sv
// ----------------------------------------------------------------------------
// bcd_seg_timebase_if
//
// Purpose:
//   Bundles the display-facing signals of bcd_seg_timebase into one interface.
//   The digit value enters on this bundle. The segment drive and the two
//   timebases (square waves plus their rising-edge ticks) leave on it.
//   The clock and reset remain plain ports on the design.
//
// Signals:
//   bcd     [3:0]  digit value to display           (master -> slave)
//   seg     [6:0]  active-low segments, seg[0]=a    (slave  -> master)
//   sig1s          1 s square wave, 50% duty        (slave  -> master)
//   sig4ms         4 ms square wave, 50% duty       (slave  -> master)
//   tick1s         one-cycle pulse on sig1s rise    (slave  -> master)
//   tick4ms        one-cycle pulse on sig4ms rise   (slave  -> master)
//
// Modports:
//   master : the time-register / digit-mux side
//   slave  : the bcd_seg_timebase block itself
// ----------------------------------------------------------------------------
interface bcd_seg_timebase_if;

    logic [3:0] bcd;
    logic [6:0] seg;
    logic       sig1s;
    logic       sig4ms;
    logic       tick1s;
    logic       tick4ms;

    // Digit mux / time registers: drives the digit and consumes the outputs.
    modport master (
        output bcd,
        input  seg,
        input  sig1s,
        input  sig4ms,
        input  tick1s,
        input  tick4ms
    );

    // Display-support block: decodes the digit and generates the timebases.
    modport slave (
        input  bcd,
        output seg,
        output sig1s,
        output sig4ms,
        output tick1s,
        output tick4ms
    );

endinterface

// File: rtl/bcd_seg_timebase.sv
// ----------------------------------------------------------------------------
// bcd_seg_timebase
//
// Purpose:
//   Display-support block for a 4-digit multiplexed seven-segment display.
//   - BCD to seven-segment decoder. It is purely combinational, with zero
//     latency and active-low outputs. Codes 10..15 blank the digit.
//   - 1 s timebase: a square wave with a half-period of HALF_1S sysclk cycles.
//     It drives the decimal-point blink.
//   - 4 ms timebase: a square wave with a half-period of HALF_4MS sysclk
//     cycles. It clocks the digit-scan counter.
//   - Each timebase also has a one-cycle tick that is high in the same cycle
//     that its square wave becomes 1.
//
// Parameters:
//   HALF_1S   sysclk cycles per half-period of sig1s  (must be >= 2)
//   HALF_4MS  sysclk cycles per half-period of sig4ms (must be >= 2)
//
// Ports:
//   sysclk   system clock; every state update happens on its rising edge
//   rst_n    asynchronous, active-low reset
//   bus      bcd_seg_timebase_if.slave
//            (bcd in; seg, sig1s, sig4ms, tick1s, tick4ms out)
// ----------------------------------------------------------------------------
module bcd_seg_timebase #(
    parameter int HALF_1S  = 25_000_000,
    parameter int HALF_4MS = 100_000
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    bcd_seg_timebase_if.slave     bus
);

    // Each counter only needs to reach HALF-1, so clog2(HALF) bits are enough.
    localparam int W1 = (HALF_1S  > 2) ? $clog2(HALF_1S)  : 1;
    localparam int W4 = (HALF_4MS > 2) ? $clog2(HALF_4MS) : 1;

    localparam logic [W1-1:0] CNT1_LAST = W1'(HALF_1S  - 1);
    localparam logic [W4-1:0] CNT4_LAST = W4'(HALF_4MS - 1);

    logic [W1-1:0] cnt1_q, cnt1_d;
    logic          sig1s_q, sig1s_d;
    logic          tick1s_q, tick1s_d;

    logic [W4-1:0] cnt4_q, cnt4_d;
    logic          sig4ms_q, sig4ms_d;
    logic          tick4ms_q, tick4ms_d;

    logic [6:0]    seg_d;

    // Decoder for active-low segments, written as g..a.
    // Codes 10..15 are not valid BCD and leave every segment off.
    always_comb begin
        seg_d = 7'b1111111;
        case (bus.bcd)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b1111111;
        endcase
    end

    // 1 s divider next state.
    // On the last count of a half-period the counter wraps and the wave
    // toggles. The tick is computed from the wave's current value, so the
    // tick flop asserts in the same cycle the wave flop becomes 1. Falling
    // transitions never produce a tick.
    always_comb begin
        cnt1_d   = cnt1_q + W1'(1);
        sig1s_d  = sig1s_q;
        tick1s_d = 1'b0;
        if (cnt1_q == CNT1_LAST) begin
            cnt1_d   = '0;
            sig1s_d  = ~sig1s_q;
            tick1s_d = ~sig1s_q;
        end
    end

    // 4 ms divider next state. It has the same structure as the 1 s divider
    // and runs fully independently of it.
    always_comb begin
        cnt4_d    = cnt4_q + W4'(1);
        sig4ms_d  = sig4ms_q;
        tick4ms_d = 1'b0;
        if (cnt4_q == CNT4_LAST) begin
            cnt4_d    = '0;
            sig4ms_d  = ~sig4ms_q;
            tick4ms_d = ~sig4ms_q;
        end
    end

    // Divider state registers. Reset clears the counters and every
    // registered output immediately. The phase restarts from zero on release,
    // so the first rise lands on the HALF-th edge after reset is deasserted.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_q    <= '0;
            sig1s_q   <= 1'b0;
            tick1s_q  <= 1'b0;
            cnt4_q    <= '0;
            sig4ms_q  <= 1'b0;
            tick4ms_q <= 1'b0;
        end else begin
            cnt1_q    <= cnt1_d;
            sig1s_q   <= sig1s_d;
            tick1s_q  <= tick1s_d;
            cnt4_q    <= cnt4_d;
            sig4ms_q  <= sig4ms_d;
            tick4ms_q <= tick4ms_d;
        end
    end

    assign bus.seg     = seg_d;
    assign bus.sig1s   = sig1s_q;
    assign bus.sig4ms  = sig4ms_q;
    assign bus.tick1s  = tick1s_q;
    assign bus.tick4ms = tick4ms_q;

endmodule

// File: tb/tb_bcd_seg_timebase.sv
// ----------------------------------------------------------------------------
// tb_bcd_seg_timebase
//
// Purpose:
//   Self-checking bench for bcd_seg_timebase, run with HALF_1S=10 and
//   HALF_4MS=4. The stimulus process pushes expected values into a
//   scoreboard queue. Each entry is tagged with the falling-edge sample it
//   belongs to. A separate monitor pops and compares those entries on every
//   falling edge.
// ----------------------------------------------------------------------------
module tb_bcd_seg_timebase;

    localparam int HALF_1S  = 10;
    localparam int HALF_4MS = 4;

    localparam int SEL_SEG     = 0;
    localparam int SEL_SIG1S   = 1;
    localparam int SEL_SIG4MS  = 2;
    localparam int SEL_TICK1S  = 3;
    localparam int SEL_TICK4MS = 4;

    typedef struct {
        int         sample;
        int         sel;
        logic [6:0] expVal;
    } sbEntry_t;

    logic sysclk;
    logic rst_n;

    bcd_seg_timebase_if busIf ();

    bcd_seg_timebase #(
        .HALF_1S  (HALF_1S),
        .HALF_4MS (HALF_4MS)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (busIf)
    );

    // Hand-written decoder table, indexed by the bcd value (g..a, active-low).
    logic [6:0] segTable [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    string selName [5] = '{"seg", "sig1s", "sig4ms", "tick1s", "tick4ms"};

    sbEntry_t sbQueue[$];
    int       sampleNo   = 0;
    int       edgeNo     = 0;
    int       bcdSeq     = 0;
    int       checkCount = 0;
    int       failCount  = 0;

    int   toggles1s  = 0;
    int   toggles4ms = 0;
    int   high1s     = 0;
    int   high4ms    = 0;
    logic prev1s     = 1'b0;
    logic prev4ms    = 1'b0;

    // Free-running 10 ns system clock.
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Hard time limit, so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Records one comparison and reports it if the values differ.
    function automatic void checkOutput(input string name, input logic [6:0] actualVal,
                                        input logic [6:0] expectedVal);
        checkCount++;
        if (actualVal !== expectedVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, actualVal, expectedVal, $time);
        end
    endfunction

    function automatic logic [6:0] actualOf(input int sel);
        case (sel)
            SEL_SEG:     return busIf.seg;
            SEL_SIG1S:   return {6'b0, busIf.sig1s};
            SEL_SIG4MS:  return {6'b0, busIf.sig4ms};
            SEL_TICK1S:  return {6'b0, busIf.tick1s};
            default:     return {6'b0, busIf.tick4ms};
        endcase
    endfunction

    // Reference model in closed form, given k edges since reset release.
    function automatic logic expSig(input int k, input int half);
        return ((k / half) % 2) == 1;
    endfunction

    function automatic logic expTick(input int k, input int half);
        return (k > 0) && ((k % (2 * half)) == half);
    endfunction

    function automatic void push(input int sel, input logic [6:0] expVal);
        sbEntry_t e;
        e.sample = sampleNo + 1;
        e.sel    = sel;
        e.expVal = expVal;
        sbQueue.push_back(e);
    endfunction

    // Monitor: on each falling edge, compare every entry queued for this sample.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge sysclk);
            sampleNo++;
            while (sbQueue.size() > 0 && sbQueue[0].sample <= sampleNo) begin
                e = sbQueue.pop_front();
                if (e.sample < sampleNo) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL stale_%s: entry for sample %0d seen at sample %0d",
                             selName[e.sel], e.sample, sampleNo);
                end else begin
                    checkOutput(selName[e.sel], actualOf(e.sel), e.expVal);
                end
            end
        end
    end

    // Runs nCycles clock cycles. Each cycle presents a fresh bcd code and
    // queues the expected outputs for the next falling edge.
    task automatic applyStimulus(input int nCycles, input bit holdReset);
        for (int i = 0; i < nCycles; i++) begin
            @(posedge sysclk);
            #1;
            if (!holdReset) edgeNo++;
            busIf.bcd = 4'(bcdSeq);
            bcdSeq++;
            push(SEL_SEG, segTable[busIf.bcd]);
            if (holdReset) begin
                push(SEL_SIG1S,   7'd0);
                push(SEL_SIG4MS,  7'd0);
                push(SEL_TICK1S,  7'd0);
                push(SEL_TICK4MS, 7'd0);
            end else begin
                push(SEL_SIG1S,   {6'b0, expSig(edgeNo, HALF_1S)});
                push(SEL_SIG4MS,  {6'b0, expSig(edgeNo, HALF_4MS)});
                push(SEL_TICK1S,  {6'b0, expTick(edgeNo, HALF_1S)});
                push(SEL_TICK4MS, {6'b0, expTick(edgeNo, HALF_4MS)});
            end
            if (busIf.sig1s !== prev1s)   toggles1s++;
            if (busIf.sig4ms !== prev4ms) toggles4ms++;
            if (busIf.sig1s === 1'b1)     high1s++;
            if (busIf.sig4ms === 1'b1)    high4ms++;
            prev1s  = busIf.sig1s;
            prev4ms = busIf.sig4ms;
        end
    endtask

    // Releases reset on a falling edge, so the next rising edge is edge 1.
    task automatic releaseReset();
        @(negedge sysclk);
        rst_n  = 1'b1;
        edgeNo = 0;
    endtask

    // Asserts reset between clock edges. The registered outputs must clear
    // immediately, without waiting for a rising edge.
    task automatic midCycleReset(input string tag);
        @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_sig1s"},   {6'b0, busIf.sig1s},   7'd0);
        checkOutput({tag, "_sig4ms"},  {6'b0, busIf.sig4ms},  7'd0);
        checkOutput({tag, "_tick1s"},  {6'b0, busIf.tick1s},  7'd0);
        checkOutput({tag, "_tick4ms"}, {6'b0, busIf.tick4ms}, 7'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        busIf.bcd = 4'd5;
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] reset state and seg while in reset");
        checkOutput("rst_sig1s",   {6'b0, busIf.sig1s},   7'd0);
        checkOutput("rst_sig4ms",  {6'b0, busIf.sig4ms},  7'd0);
        checkOutput("rst_tick1s",  {6'b0, busIf.tick1s},  7'd0);
        checkOutput("rst_tick4ms", {6'b0, busIf.tick4ms}, 7'd0);
        checkOutput("rst_seg5",    busIf.seg,             7'b0010010);

        // Reset held for 50 clocks, while seg sweeps all 16 codes several times.
        applyStimulus(50, 1'b1);

        // Run to edge 7 (sig4ms high), then reset asynchronously mid-cycle.
        $display("[TB] divider timing and mid-cycle reset at edge 7");
        releaseReset();
        applyStimulus(7, 1'b0);
        midCycleReset("async7");
        applyStimulus(3, 1'b1);

        // Restart: the first sig4ms rise must again be on edge 4. Then reset
        // at edge 12, where sig1s, sig4ms and tick4ms are all high.
        releaseReset();
        applyStimulus(12, 1'b0);
        midCycleReset("async12");
        applyStimulus(2, 1'b1);

        // Long run of 1000 edges: every cycle is checked by the scoreboard,
        // and toggle and duty counts are accumulated.
        $display("[TB] long run of 1000 cycles");
        toggles1s  = 0;
        toggles4ms = 0;
        high1s     = 0;
        high4ms    = 0;
        prev1s     = busIf.sig1s;
        prev4ms    = busIf.sig4ms;
        releaseReset();
        applyStimulus(1000, 1'b0);
        checkOutput("toggles1s",  7'(toggles1s  / 8), 7'(100 / 8));
        checkOutput("toggles1s_lsb", 7'(toggles1s % 8), 7'(100 % 8));
        checkOutput("toggles4ms", 7'(toggles4ms / 8), 7'(250 / 8));
        checkOutput("toggles4ms_lsb", 7'(toggles4ms % 8), 7'(250 % 8));
        checkOutput("high1s",  7'(high1s  / 8), 7'(500 / 8));
        checkOutput("high1s_lsb",  7'(high1s  % 8), 7'(500 % 8));
        checkOutput("high4ms", 7'(high4ms / 8), 7'(500 / 8));
        checkOutput("high4ms_lsb", 7'(high4ms % 8), 7'(500 % 8));

        // Drain the scoreboard. Anything left over means the monitor missed it.
        repeat (3) @(negedge sysclk);
        #1;
        if (sbQueue.size() != 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d scoreboard entries left, required 0", sbQueue.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
